// File: rtl/rx_uart.sv
// 8N1 UART receiver with 16x oversampling, start-glitch rejection, framing-error
// reporting and break suppression (a held-low line yields a single frame).
module rx_uart #(
    parameter int NB_DATA  = 8,
    parameter int SB_TICK  = 16,
    parameter int NB_STATE = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_s_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done_tick,
    output logic               o_frame_err
);

    // state | meaning
    // IDLE  | waiting for a falling edge on the line (blocked while break_hold)
    // START | timing to mid start bit, rejecting glitches
    // DATA  | sampling NB_DATA bits at mid-bit, LSB first
    // STOP  | timing the stop bit, then publishing the byte
    typedef enum logic [NB_STATE-1:0] {
        IDLE  = 0,
        START = 1,
        DATA  = 2,
        STOP  = 3
    } state_t;

    localparam int NB_TICK = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int NB_BIT  = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [NB_TICK-1:0] S_MID  = NB_TICK'(7);
    localparam logic [NB_TICK-1:0] S_BIT  = NB_TICK'(15);
    localparam logic [NB_TICK-1:0] S_STOP = NB_TICK'(SB_TICK - 1);
    localparam logic [NB_BIT-1:0]  N_LAST = NB_BIT'(NB_DATA - 1);

    logic               rx_meta;
    logic               rx_s;
    state_t             state;
    logic [NB_TICK-1:0] s;
    logic [NB_BIT-1:0]  n;
    logic [NB_DATA-1:0] b;
    logic               break_hold;
    logic               stop_ok;
    logic               stop_level;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    // With a single stop bit the mid-stop sample and completion share a tick.
    assign stop_level = (SB_TICK == 16) ? rx_s : stop_ok;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state          <= IDLE;
            s              <= '0;
            n              <= '0;
            b              <= '0;
            break_hold     <= 1'b0;
            stop_ok        <= 1'b1;
            o_data         <= '0;
            o_rx_done_tick <= 1'b0;
            o_frame_err    <= 1'b0;
        end else begin
            o_rx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_s) begin
                        break_hold <= 1'b0;
                    end else if (!break_hold) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (i_s_tick) begin
                        if (s == S_MID) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + NB_TICK'(1);
                        end
                    end
                end
                DATA: begin
                    if (i_s_tick) begin
                        if (s == S_BIT) begin
                            b <= {rx_s, b[NB_DATA-1:1]};
                            s <= '0;
                            if (n == N_LAST) begin
                                state <= STOP;
                            end else begin
                                n <= n + NB_BIT'(1);
                            end
                        end else begin
                            s <= s + NB_TICK'(1);
                        end
                    end
                end
                STOP: begin
                    if (i_s_tick) begin
                        if (s == S_BIT) begin
                            stop_ok <= rx_s;
                        end
                        if (s == S_STOP) begin
                            o_data         <= b;
                            o_rx_done_tick <= 1'b1;
                            o_frame_err    <= ~stop_level;
                            break_hold     <= ~stop_level;
                            state          <= IDLE;
                        end else begin
                            s <= s + NB_TICK'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
